// File: rtl/gate_vector_checker.sv
// gate_vector_checker: drives every {a,b} input combination into a
// two-input gate under test. It holds each vector for SETTLE+1 cycles,
// compares the gate output against the TRUTH table, and reports
// pass/fail, the mismatch count and the first failing vector.
module gate_vector_checker #(
  parameter logic [3:0] TRUTH       = 4'b1000,
  parameter int         SETTLE      = 1,
  parameter bit         STOP_ON_ERR = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

  state_t     state;
  logic [3:0] settle_cnt;

  logic [1:0] vec;
  logic       window_end;
  logic       mismatch;
  logic [2:0] err_next;
  logic       run_end;

  // Compare-edge decode for the vector currently on {a,b}
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    vec        = {a, b};
    window_end = 1'b0;
    mismatch   = 1'b0;
    err_next   = err_count;
    run_end    = 1'b0;
    if (state == RUN && settle_cnt == SETTLE_LAST) begin
      window_end = 1'b1;
      mismatch   = (dut_out != TRUTH[vec]);
      err_next   = err_count + {2'b00, mismatch};
      run_end    = (vec == 2'b11) || (STOP_ON_ERR && mismatch);
    end
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= RUN;
            settle_cnt     <= '0;
            a              <= 1'b0;
            b              <= 1'b0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end

        RUN: begin
          if (window_end) begin
            settle_cnt <= '0;
            err_count  <= err_next;
            if (mismatch && !fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_vec <= vec;
            end
            if (run_end) begin
              state <= DONE;
              a     <= 1'b0;
              b     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 3'd0);
            end else begin
              {a, b} <= vec + 2'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker. Three instances share one clock:
//   0: defaults, gate = AND or stuck-at-1 (selectable)
//   1: STOP_ON_ERR=1, gate = OR
//   2: TRUTH=0110, SETTLE=3, gate = XOR
// A timeline model predicts every output from the elapsed cycles since the
// start edge. It is checked on each falling edge, alongside literal
// expectations for the scenarios.
module tb_gate_vector_checker;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s   [N];
  logic       start_s [N];
  logic       a_s     [N];
  logic       b_s     [N];
  logic       dout_s  [N];
  logic       busy_s  [N];
  logic       done_s  [N];
  logic       pass_s  [N];
  logic [2:0] ec_s    [N];
  logic       fv_s    [N];
  logic [1:0] ffv_s   [N];

  logic g0_stuck = 1'b0;

  assign dout_s[0] = g0_stuck ? 1'b1 : (a_s[0] & b_s[0]);
  assign dout_s[1] = a_s[1] | b_s[1];
  assign dout_s[2] = a_s[2] ^ b_s[2];

  gate_vector_checker u_and (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
    .dut_out(dout_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(ec_s[0]), .fail_valid(fv_s[0]), .first_fail_vec(ffv_s[0])
  );

  gate_vector_checker #(.STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .dut_out(dout_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(ec_s[1]), .fail_valid(fv_s[1]), .first_fail_vec(ffv_s[1])
  );

  gate_vector_checker #(.TRUTH(4'b0110), .SETTLE(3)) u_xor (
    .clk(clk), .reset(rst_s[2]), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
    .dut_out(dout_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
    .err_count(ec_s[2]), .fail_valid(fv_s[2]), .first_fail_vec(ffv_s[2])
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per-instance configuration: hold length, expected truth table, stop mode.
  int tb_hold  [N] = '{2, 2, 4};
  int tb_truth [N] = '{8, 8, 6};
  bit tb_stop  [N] = '{1'b0, 1'b1, 1'b0};

  // Model state: phase 0=idle 1=running 2=done cycle.
  int       cyc = 0;
  int       m_phase [N];
  int       m_rs    [N];
  int       m_nend  [N];
  bit [3:0] m_mm    [N];
  bit       m_had   [N];

  function automatic int gate_val(input int i, input int v);
    int av, bv;
    av = v / 2;
    bv = v % 2;
    case (i)
      0:       return g0_stuck ? 1 : (av & bv);
      1:       return av | bv;
      default: return av ^ bv;
    endcase
  endfunction

  task automatic model_start(input int i);
    bit [3:0] mm;
    int       tv;
    int       nend;
    mm = '0;
    tv = tb_truth[i];
    for (int v = 0; v < 4; v++)
      mm[v] = (gate_val(i, v) != ((tv >> v) & 1));
    nend = 4;
    if (tb_stop[i]) begin
      for (int v = 3; v >= 0; v--)
        if (mm[v]) nend = v + 1;
    end
    m_mm[i]    = mm;
    m_nend[i]  = nend;
    m_rs[i]    = cyc;
    m_had[i]   = 1'b1;
    m_phase[i] = 1;
  endtask

  task automatic model_step();
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst_s[i] === 1'b1) begin
        m_phase[i] = 0;
        m_had[i]   = 1'b0;
      end else begin
        case (m_phase[i])
          0: if (start_s[i] === 1'b1) model_start(i);
          1: if (cyc - m_rs[i] == tb_hold[i] * m_nend[i]) m_phase[i] = 2;
          default: m_phase[i] = 0;
        endcase
      end
    end
  endtask

  task automatic model_expect(input int i, output int ea, output int eb, output int ebusy,
                              output int edone, output int epass, output int eerr,
                              output int efv, output int effv);
    int cd;
    int vv;
    cd = 0;
    vv = 0;
    if (m_phase[i] == 1) begin
      cd = (cyc - m_rs[i]) / tb_hold[i];
      vv = cd;
    end else if (m_had[i]) begin
      cd = m_nend[i];
    end
    eerr = 0;
    effv = 0;
    for (int v = cd - 1; v >= 0; v--) begin
      if (m_mm[i][v]) begin
        eerr++;
        effv = v;
      end
    end
    efv   = (eerr > 0) ? 1 : 0;
    ea    = vv / 2;
    eb    = vv % 2;
    ebusy = (m_phase[i] == 1) ? 1 : 0;
    edone = (m_phase[i] == 2) ? 1 : 0;
    epass = (m_phase[i] != 1 && m_had[i] && eerr == 0) ? 1 : 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0;
      m_rs[i]    = 0;
      m_nend[i]  = 4;
      m_mm[i]    = '0;
      m_had[i]   = 1'b0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;

  initial begin
    int ea, eb, ebusy, edone, epass, eerr, efv, effv;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < N; i++) begin
          model_expect(i, ea, eb, ebusy, edone, epass, eerr, efv, effv);
          check($sformatf("i%0d a", i),          int'(a_s[i]),    ea);
          check($sformatf("i%0d b", i),          int'(b_s[i]),    eb);
          check($sformatf("i%0d busy", i),       int'(busy_s[i]), ebusy);
          check($sformatf("i%0d done", i),       int'(done_s[i]), edone);
          check($sformatf("i%0d pass", i),       int'(pass_s[i]), epass);
          check($sformatf("i%0d err_count", i),  int'(ec_s[i]),   eerr);
          check($sformatf("i%0d fail_valid", i), int'(fv_s[i]),   efv);
          check($sformatf("i%0d first_fail", i), int'(ffv_s[i]),  effv);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Pulse start for one edge, then count edges until done is seen.
  // Returns -1 if done never arrives within the budget.
  task automatic run_meas(input int i, output int lat);
    lat = -1;
    start_s[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[i] = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done_s[i] === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_done(input int i, output bit got);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_s[i] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat;
    bit got;
    int last;
    int exp_ab [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    for (int i = 0; i < N; i++) begin
      rst_s[i]   = 1'b1;
      start_s[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset busy",       int'(busy_s[0]), 0);
    check("reset err_count",  int'(ec_s[0]),   0);
    check("reset first_fail", int'(ffv_s[0]),  0);
    for (int i = 0; i < N; i++) rst_s[i] = 1'b0;
    repeat (2) @(negedge clk);

    // Ideal AND, defaults: two cycles per vector, done after edge k+8.
    start_s[0] = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      check($sformatf("and vec n=%0d", n), int'({a_s[0], b_s[0]}), exp_ab[n]);
      check($sformatf("and no done n=%0d", n), int'(done_s[0]), 0);
    end
    @(negedge clk);
    check("and done at k+8", int'(done_s[0]), 1);
    check("and pass",        int'(pass_s[0]), 1);
    check("and err_count",   int'(ec_s[0]),   0);
    repeat (3) @(negedge clk);
    check("and pass held idle", int'(pass_s[0]), 1);

    // Stuck-at-1 gate: mismatches on 00, 01, 10.
    g0_stuck = 1'b1;
    run_meas(0, lat);
    check("stuck latency",    lat,             8);
    check("stuck err_count",  int'(ec_s[0]),   3);
    check("stuck fail_valid", int'(fv_s[0]),   1);
    check("stuck first_fail", int'(ffv_s[0]),  0);
    check("stuck pass",       int'(pass_s[0]), 0);
    repeat (2) @(negedge clk);
    g0_stuck = 1'b0;

    // STOP_ON_ERR with OR gate: stops at vector 01.
    run_meas(1, lat);
    check("stop latency",    lat,             4);
    check("stop err_count",  int'(ec_s[1]),   1);
    check("stop first_fail", int'(ffv_s[1]),  1);
    check("stop a",          int'(a_s[1]),    0);
    check("stop b",          int'(b_s[1]),    0);
    check("stop pass",       int'(pass_s[1]), 0);
    repeat (2) @(negedge clk);

    // Reset during vector 10 aborts the run with no done pulse.
    start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort vec before reset", int'({a_s[0], b_s[0]}), 2);
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
    check("abort busy",      int'(busy_s[0]), 0);
    check("abort ab",        int'({a_s[0], b_s[0]}), 0);
    check("abort err_count", int'(ec_s[0]),   0);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check($sformatf("abort no done n=%0d", n), int'(done_s[0]), 0);
    end
    run_meas(0, lat);
    check("after abort latency", lat,             8);
    check("after abort pass",    int'(pass_s[0]), 1);
    repeat (2) @(negedge clk);

    // XOR with SETTLE=3: four cycles per vector, done after edge k+16.
    run_meas(2, lat);
    check("xor latency",   lat,             16);
    check("xor pass",      int'(pass_s[2]), 1);
    check("xor err_count", int'(ec_s[2]),   0);
    repeat (2) @(negedge clk);

    // Start held high: back-to-back runs every 10 edges, results cleared.
    g0_stuck   = 1'b1;
    start_s[0] = 1'b1;
    last = -1;
    for (int r = 0; r < 3; r++) begin
      wait_done(0, got);
      check($sformatf("b2b done seen r=%0d", r), int'(got), 1);
      check($sformatf("b2b err_count r=%0d", r), int'(ec_s[0]), 3);
      if (r > 0) check($sformatf("b2b period r=%0d", r), cyc - last, 10);
      last = cyc;
      if (r == 2) start_s[0] = 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("b2b idle after release", int'(busy_s[0]), 0);
    g0_stuck = 1'b0;

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected summary before t=%0t", $time);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 SHALL have parameter TRUTH, default 4'b1000, expected gate output per vector; bit i is the expected value for {a,b}=i (default = AND).
REQ-002 SHALL have parameter SETTLE, default 1, range 0..15, extra cycles each vector is held before its compare.
REQ-003 SHALL have parameter STOP_ON_ERR, default 0; 1 = end the run at the first mismatch.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  run request; sampled only in IDLE.
REQ-007 SHALL have port a  output  1  stimulus bit to the gate under test (vector MSB).
REQ-008 SHALL have port b  output  1  stimulus bit to the gate under test (vector LSB).
REQ-009 SHALL have port dut_out  input  1  gate-under-test output, combinational from a/b.
REQ-010 SHALL have port busy  output  1  high while a run is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-012 SHALL have port pass  output  1  result of the last completed run; 1 = no mismatch.
REQ-013 SHALL have port err_count  output  3  mismatches in the current or last run, range 0..4.
REQ-014 SHALL have port fail_valid  output  1  at least one mismatch recorded in the current or last run.
REQ-015 SHALL have port first_fail_vec  output  2  {a,b} of the first mismatching vector; 0 when fail_valid=0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-017 SHALL move IDLE->RUN on the edge where start=1, loading vector 0 onto {a,b} at that edge and clearing err_count, fail_valid, first_fail_vec and pass.
REQ-018 SHALL apply vectors in order 00, 01, 10, 11, each held for exactly SETTLE+1 cycles.
REQ-019 SHALL compare dut_out with TRUTH[{a,b}] on the last edge of each vector window, and on that same edge advance {a,b} to the next vector.
REQ-020 SHALL, on a mismatch, increment err_count; if fail_valid=0, SHALL also set fail_valid=1 and latch first_fail_vec={a,b}.
REQ-021 SHALL move RUN->DONE at the compare edge of vector 11, or at the first mismatch edge when STOP_ON_ERR=1.
REQ-022 SHALL, on entering DONE, drive {a,b} to 00 and set pass=1 only when the final err_count is 0.
REQ-023 SHALL hold busy=1 exactly while in RUN.
REQ-024 SHALL assert done for exactly the one cycle spent in DONE, then return unconditionally to IDLE.
REQ-025 SHALL make a full run latency 4*(SETTLE+1) edges from the start edge to the DONE entry edge; with SETTLE=1, done is high in the cycle after edge k+8.
REQ-026 SHALL ignore start in RUN and DONE; start held high SHALL begin the next run on the IDLE cycle following DONE.
REQ-027 SHALL hold pass, err_count, fail_valid and first_fail_vec stable in IDLE until the next accepted start.
REQ-028 SHALL use a settle counter no wider than 4 bits; SETTLE=0 gives one cycle per vector.

Reset
REQ-029 SHALL, when reset=1 at a rising edge, force state IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0 and first_fail_vec=0, with reset taking priority over start.
REQ-030 SHALL abort an in-progress run on reset without asserting done; the aborted run's partial results SHALL NOT be visible afterwards.

Verification
REQ-031 SHALL cover: ideal AND model, defaults, start pulse at edge k -> {a,b}=00,01,10,11 each for 2 cycles; done high after edge k+8; pass=1; err_count=0.
REQ-032 SHALL cover: DUT stuck-at-1, defaults -> err_count=3, fail_valid=1, first_fail_vec=00, pass=0.
REQ-033 SHALL cover: STOP_ON_ERR=1 with an OR model -> mismatch at vector 01; done after edge k+4; err_count=1; first_fail_vec=01; a=b=0.
REQ-034 SHALL cover: reset asserted for 1 cycle during vector 10 -> next cycle busy=0, a=b=0, err_count=0, no done pulse; a following start gives a full passing run.
REQ-035 SHALL cover: TRUTH=4'b0110 with SETTLE=3 and an XOR model -> each vector held 4 cycles; done after edge k+16; pass=1.
REQ-036 SHALL cover: start held high continuously -> back-to-back runs, each beginning the cycle after done, with results cleared at each new start.
